// File: rtl/bank_isu_issue_sched_if.sv
// Issue-queue view, issue-stage handshake and channel credit signals of bank_isu_issue_sched.
// master: the scheduler; slave: the surrounding IQ, bank pipeline and credit manager.
interface bank_isu_issue_sched_if #(
    parameter int unsigned PTR_WIDTH   = 8,
    parameter int unsigned CHANNEL_NUM = 3
);
    localparam int unsigned DEPTH = 1 << PTR_WIDTH;

    logic [DEPTH-1:0]       iq_valid_array;
    logic [DEPTH-1:0]       credit_allow_array;
    logic [DEPTH-1:0]       op_is_read_array;
    logic [2*DEPTH-1:0]     ch_id_flat;
    logic [PTR_WIDTH-1:0]   iq_bottom_ptr;

    logic                   isu_valid;
    logic                   isu_ready;
    logic [PTR_WIDTH-1:0]   isu_ptr;
    logic [1:0]             isu_ch_id;
    logic                   isu_op_is_read;

    logic                   iq_dequeue;
    logic [PTR_WIDTH-1:0]   iq_dequeue_ptr;

    logic [CHANNEL_NUM-1:0] ch_rsp_valid;
    logic [CHANNEL_NUM-1:0] channels_credit_release;
    logic                   inflight_err;

    modport master (
        input  iq_valid_array, credit_allow_array, op_is_read_array, ch_id_flat, iq_bottom_ptr,
        input  isu_ready, ch_rsp_valid,
        output isu_valid, isu_ptr, isu_ch_id, isu_op_is_read,
        output iq_dequeue, iq_dequeue_ptr, channels_credit_release, inflight_err
    );

    modport slave (
        output iq_valid_array, credit_allow_array, op_is_read_array, ch_id_flat, iq_bottom_ptr,
        output isu_ready, ch_rsp_valid,
        input  isu_valid, isu_ptr, isu_ch_id, isu_op_is_read,
        input  iq_dequeue, iq_dequeue_ptr, channels_credit_release, inflight_err
    );
endinterface

// File: rtl/bank_isu_issue_sched.sv
// Bank issue scheduler: picks a credit-allowed IQ entry into a registered issue stage and tracks
// per-channel in-flight reads. Define BANK_ISU_SCHED_AGE_ORDER_EN for oldest-first scanning.
module bank_isu_issue_sched #(
    parameter int unsigned PTR_WIDTH    = 8,
    parameter int unsigned DEPTH        = 1 << PTR_WIDTH,
    parameter int unsigned CHANNEL_NUM  = 3,
    parameter int unsigned MAX_INFLIGHT = 8
) (
    input logic                    clk,
    input logic                    rst,
    bank_isu_issue_sched_if.master bus
);
    localparam int unsigned CNT_WIDTH = $clog2(MAX_INFLIGHT) + 1;

    typedef enum logic [0:0] {StEmpty, StFull} state_e;

    state_e               state_q;
    logic [PTR_WIDTH-1:0] ptr_q;
    logic [1:0]           ch_q;
    logic                 rd_q;

    logic [CHANNEL_NUM-1:0][CNT_WIDTH-1:0] inflight_q, inflight_d;
    logic [CHANNEL_NUM-1:0]                release_q, release_d;
    logic [CHANNEL_NUM-1:0]                issue_rd;
    logic                                  err_q, err_d;

    logic [DEPTH-1:0]     cand;
    logic                 sel_found;
    logic [PTR_WIDTH-1:0] sel_ptr;
    logic [PTR_WIDTH-1:0] scan_idx;
    logic [1:0]           sel_ch;
    logic                 sel_rd;
    logic                 hs;

    assign hs = (state_q == StFull) & bus.isu_ready;

    // The held entry is still valid in the IQ until the cycle after dequeue, so hide it.
    always_comb begin
        cand = bus.iq_valid_array & bus.credit_allow_array;
        if (state_q == StFull) begin
            cand[ptr_q] = 1'b0;
        end
    end

    always_comb begin
        sel_found = 1'b0;
        sel_ptr   = '0;
        scan_idx  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
`ifdef BANK_ISU_SCHED_AGE_ORDER_EN
            scan_idx = bus.iq_bottom_ptr + PTR_WIDTH'(i);
`else
            scan_idx = PTR_WIDTH'(i);
`endif
            if (!sel_found && cand[scan_idx]) begin
                sel_found = 1'b1;
                sel_ptr   = scan_idx;
            end
        end
    end

    assign sel_ch = bus.ch_id_flat[{sel_ptr, 1'b0} +: 2];
    assign sel_rd = bus.op_is_read_array[sel_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StEmpty;
            ptr_q   <= '0;
            ch_q    <= '0;
            rd_q    <= 1'b0;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (sel_found) begin
                        state_q <= StFull;
                        ptr_q   <= sel_ptr;
                        ch_q    <= sel_ch;
                        rd_q    <= sel_rd;
                    end
                end
                StFull: begin
                    if (hs) begin
                        if (sel_found) begin
                            ptr_q <= sel_ptr;
                            ch_q  <= sel_ch;
                            rd_q  <= sel_rd;
                        end else begin
                            state_q <= StEmpty;
                        end
                    end
                end
                default: state_q <= StEmpty;
            endcase
        end
    end

    always_comb begin
        for (int unsigned c = 0; c < CHANNEL_NUM; c++) begin
            issue_rd[c] = hs & rd_q & (ch_q == 2'(c));
        end
    end

    // A read issue and a response on the same channel cancel; errors keep the counter in range.
    always_comb begin
        inflight_d = inflight_q;
        release_d  = '0;
        err_d      = err_q;
        for (int unsigned c = 0; c < CHANNEL_NUM; c++) begin
            release_d[c] = bus.ch_rsp_valid[c] & ((inflight_q[c] != '0) | issue_rd[c]);
            if (issue_rd[c] && !bus.ch_rsp_valid[c]) begin
                if (inflight_q[c] == CNT_WIDTH'(MAX_INFLIGHT)) begin
                    err_d = 1'b1;
                end else begin
                    inflight_d[c] = inflight_q[c] + CNT_WIDTH'(1);
                end
            end else if (bus.ch_rsp_valid[c] && !issue_rd[c]) begin
                if (inflight_q[c] == '0) begin
                    err_d = 1'b1;
                end else begin
                    inflight_d[c] = inflight_q[c] - CNT_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= '0;
            release_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            release_q  <= release_d;
            err_q      <= err_d;
        end
    end

    assign bus.isu_valid               = (state_q == StFull);
    assign bus.isu_ptr                 = ptr_q;
    assign bus.isu_ch_id               = ch_q;
    assign bus.isu_op_is_read          = rd_q;
    assign bus.iq_dequeue              = hs;
    assign bus.iq_dequeue_ptr          = ptr_q;
    assign bus.channels_credit_release = release_q;
    assign bus.inflight_err            = err_q;

    hold_stable_a: assert property (@(posedge clk) disable iff (rst)
        bus.isu_valid && !bus.isu_ready |=> bus.isu_valid && $stable(bus.isu_ptr));
endmodule

// File: tb/tb_bank_isu_issue_sched.sv
// Bench for bank_isu_issue_sched: pick-order table, hand-written corner sequences and a
// randomized run against a behavioural model of the IQ, issue stage and channel counters.
module tb_bank_isu_issue_sched;
    localparam int PTR_WIDTH    = 8;
    localparam int DEPTH        = 256;
    localparam int CHANNEL_NUM  = 3;
    localparam int MAX_INFLIGHT = 8;
`ifdef BANK_ISU_SCHED_AGE_ORDER_EN
    localparam bit AGE_ORDER = 1'b1;
`else
    localparam bit AGE_ORDER = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [DEPTH-1:0]       iq_v = '0;
    logic [DEPTH-1:0]       iq_a = '0;
    logic [DEPTH-1:0]       iq_r = '0;
    logic [2*DEPTH-1:0]     iq_ch = '0;
    logic [PTR_WIDTH-1:0]   bottom = '0;
    logic                   ready = 1'b0;
    logic [CHANNEL_NUM-1:0] rsp = '0;

    bank_isu_issue_sched_if #(.PTR_WIDTH(PTR_WIDTH), .CHANNEL_NUM(CHANNEL_NUM)) bus ();

    assign bus.iq_valid_array     = iq_v;
    assign bus.credit_allow_array = iq_a;
    assign bus.op_is_read_array   = iq_r;
    assign bus.ch_id_flat         = iq_ch;
    assign bus.iq_bottom_ptr      = bottom;
    assign bus.isu_ready          = ready;
    assign bus.ch_rsp_valid       = rsp;

    bank_isu_issue_sched #(
        .PTR_WIDTH   (PTR_WIDTH),
        .DEPTH       (DEPTH),
        .CHANNEL_NUM (CHANNEL_NUM),
        .MAX_INFLIGHT(MAX_INFLIGHT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Reference state: issue stage contents, per-channel outstanding reads, release, error.
    bit                   m_valid;
    int                   m_ptr;
    int                   m_ch;
    bit                   m_rd;
    int                   m_inf[CHANNEL_NUM];
    bit [CHANNEL_NUM-1:0] m_rel;
    bit                   m_err;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Oldest candidate = smallest distance from the bottom pointer (or smallest index).
    function automatic int model_pick();
        int best;
        int best_key;
        int key;
        best     = -1;
        best_key = DEPTH;
        for (int i = 0; i < DEPTH; i++) begin
            if (iq_v[i] && iq_a[i] && !(m_valid && i == m_ptr)) begin
                key = AGE_ORDER ? (i - int'(bottom) + DEPTH) % DEPTH : i;
                if (key < best_key) begin
                    best_key = key;
                    best     = i;
                end
            end
        end
        return best;
    endfunction

    task automatic set_entry(input int idx, input bit allow, input bit rd, input int ch);
        iq_v[idx]          = 1'b1;
        iq_a[idx]          = allow;
        iq_r[idx]          = rd;
        iq_ch[2*idx +: 2]  = 2'(ch);
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        ready = 1'b0;
        rsp   = '0;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        iq_v   = '0;
        iq_a   = '0;
        iq_r   = '0;
        iq_ch  = '0;
        bottom = '0;
        m_valid = 1'b0;
        m_ptr   = 0;
        m_ch    = 0;
        m_rd    = 1'b0;
        m_rel   = '0;
        m_err   = 1'b0;
        for (int c = 0; c < CHANNEL_NUM; c++) m_inf[c] = 0;
        check("rst_isu_valid", bus.isu_valid, 0);
        check("rst_isu_ptr", bus.isu_ptr, 0);
        check("rst_isu_ch_id", bus.isu_ch_id, 0);
        check("rst_isu_op_is_read", bus.isu_op_is_read, 0);
        check("rst_iq_dequeue", bus.iq_dequeue, 0);
        check("rst_release", bus.channels_credit_release, 0);
        check("rst_inflight_err", bus.inflight_err, 0);
    endtask

    // One clock: check the combinational dequeue, advance the model, then check registered outputs.
    task automatic tick();
        int                   pick;
        bit                   hs;
        bit                   iss;
        int                   old_ptr;
        bit                   nv;
        int                   np;
        int                   nc;
        bit                   nr;
        int                   ninf[CHANNEL_NUM];
        bit [CHANNEL_NUM-1:0] nrel;
        bit                   nerr;
        #1;
        hs = m_valid && ready;
        check("iq_dequeue", bus.iq_dequeue, hs);
        if (hs) check("iq_dequeue_ptr", bus.iq_dequeue_ptr, m_ptr);
        pick = model_pick();
        nv   = m_valid;
        np   = m_ptr;
        nc   = m_ch;
        nr   = m_rd;
        nerr = m_err;
        nrel = '0;
        for (int c = 0; c < CHANNEL_NUM; c++) begin
            ninf[c] = m_inf[c];
            iss     = hs && m_rd && (m_ch == c);
            nrel[c] = rsp[c] && (m_inf[c] > 0 || iss);
            if (iss && !rsp[c]) begin
                if (m_inf[c] >= MAX_INFLIGHT) nerr = 1'b1;
                else ninf[c] = m_inf[c] + 1;
            end else if (rsp[c] && !iss) begin
                if (m_inf[c] == 0) nerr = 1'b1;
                else ninf[c] = m_inf[c] - 1;
            end
        end
        if (!m_valid || hs) begin
            if (pick >= 0) begin
                nv = 1'b1;
                np = pick;
                nc = int'(iq_ch[2*pick +: 2]);
                nr = iq_r[pick];
            end else begin
                nv = 1'b0;
            end
        end
        if (rst) begin
            nv   = 1'b0;
            np   = 0;
            nc   = 0;
            nr   = 1'b0;
            nrel = '0;
            nerr = 1'b0;
            for (int c = 0; c < CHANNEL_NUM; c++) ninf[c] = 0;
        end
        old_ptr = m_ptr;
        @(posedge clk);
        #1;
        m_valid = nv;
        m_ptr   = np;
        m_ch    = nc;
        m_rd    = nr;
        m_rel   = nrel;
        m_err   = nerr;
        for (int c = 0; c < CHANNEL_NUM; c++) m_inf[c] = ninf[c];
        if (rst) begin
            iq_v = '0;
            iq_a = '0;
        end else if (hs) begin
            iq_v[old_ptr] = 1'b0;
        end
        check("isu_valid", bus.isu_valid, m_valid);
        if (m_valid) begin
            check("isu_ptr", bus.isu_ptr, m_ptr);
            check("isu_ch_id", bus.isu_ch_id, m_ch);
            check("isu_op_is_read", bus.isu_op_is_read, m_rd);
        end
        check("credit_release", bus.channels_credit_release, m_rel);
        check("inflight_err", bus.inflight_err, m_err);
    endtask

    typedef struct {
        int a;
        int b;
        bit allow;
        int bot;
        bit exp_v;
        int exp_age;
        int exp_fix;
    } sel_vec_t;

    sel_vec_t vecs[8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int idx;
        vecs[0] = '{5,   9,   1'b1, 7,   1'b1, 9,   5};
        vecs[1] = '{1,   255, 1'b1, 254, 1'b1, 255, 1};
        vecs[2] = '{0,   200, 1'b1, 0,   1'b1, 0,   0};
        vecs[3] = '{100, 50,  1'b1, 60,  1'b1, 100, 50};
        vecs[4] = '{3,   -1,  1'b1, 4,   1'b1, 3,   3};
        vecs[5] = '{255, -1,  1'b1, 0,   1'b1, 255, 255};
        vecs[6] = '{128, 127, 1'b1, 128, 1'b1, 128, 127};
        vecs[7] = '{10,  -1,  1'b0, 0,   1'b0, 0,   0};

        for (int k = 0; k < 8; k++) begin
            do_reset();
            bottom = PTR_WIDTH'(vecs[k].bot);
            set_entry(vecs[k].a, vecs[k].allow, 1'b0, 0);
            if (vecs[k].b >= 0) set_entry(vecs[k].b, vecs[k].allow, 1'b0, 0);
            tick();
            check("tbl_valid", bus.isu_valid, vecs[k].exp_v);
            if (vecs[k].exp_v) begin
                check("tbl_ptr", bus.isu_ptr, AGE_ORDER ? vecs[k].exp_age : vecs[k].exp_fix);
            end
        end

        // Held entry stays put under backpressure, then the next candidate follows.
        do_reset();
        set_entry(3, 1'b1, 1'b0, 0);
        set_entry(4, 1'b1, 1'b0, 0);
        tick();
        check("hold_first_ptr", bus.isu_ptr, 3);
        repeat (4) begin
            tick();
            check("hold_ptr", bus.isu_ptr, 3);
            check("hold_no_dequeue", bus.iq_dequeue, 0);
        end
        ready = 1'b1;
        #1;
        check("hold_dequeue", bus.iq_dequeue, 1);
        check("hold_dequeue_ptr", bus.iq_dequeue_ptr, 3);
        tick();
        check("hold_next_ptr", bus.isu_ptr, 4);

        // Entry without credit is never issued; issues one cycle after credit arrives.
        do_reset();
        set_entry(10, 1'b0, 1'b0, 0);
        repeat (3) begin
            tick();
            check("nocredit_valid", bus.isu_valid, 0);
        end
        iq_a[10] = 1'b1;
        tick();
        check("credit_valid", bus.isu_valid, 1);
        check("credit_ptr", bus.isu_ptr, 10);

        // Three reads on ch1, three responses, then the counter is back at zero.
        do_reset();
        ready = 1'b1;
        set_entry(20, 1'b1, 1'b1, 1);
        set_entry(21, 1'b1, 1'b1, 1);
        set_entry(22, 1'b1, 1'b1, 1);
        repeat (4) tick();
        check("ch1_drained", bus.isu_valid, 0);
        ready = 1'b0;
        rsp   = 3'b010;
        repeat (3) begin
            tick();
            check("ch1_release", bus.channels_credit_release, 3'b010);
            check("ch1_no_err", bus.inflight_err, 0);
        end
        rsp = '0;
        tick();
        check("ch1_release_done", bus.channels_credit_release, 3'b000);
        rsp = 3'b010;
        tick();
        check("ch1_zero_no_release", bus.channels_credit_release, 3'b000);
        check("ch1_zero_err", bus.inflight_err, 1);
        rsp = '0;

        // Response with nothing in flight: no release, sticky error.
        do_reset();
        rsp = 3'b100;
        tick();
        check("ch2_no_release", bus.channels_credit_release, 3'b000);
        check("ch2_err", bus.inflight_err, 1);
        rsp = '0;
        repeat (3) begin
            tick();
            check("ch2_err_sticky", bus.inflight_err, 1);
        end

        // Same-cycle read issue and response on ch0 with nothing in flight.
        do_reset();
        set_entry(30, 1'b1, 1'b1, 0);
        tick();
        ready = 1'b1;
        rsp   = 3'b001;
        tick();
        check("ch0_same_release", bus.channels_credit_release, 3'b001);
        check("ch0_same_no_err", bus.inflight_err, 0);
        ready = 1'b0;
        tick();
        check("ch0_same_counter_zero", bus.channels_credit_release, 3'b000);
        check("ch0_same_err", bus.inflight_err, 1);
        rsp = '0;

        // Nine reads on ch2 saturate the counter at eight.
        do_reset();
        ready = 1'b1;
        for (int i = 0; i < 9; i++) set_entry(40 + i, 1'b1, 1'b1, 2);
        repeat (9) tick();
        check("sat_no_err_yet", bus.inflight_err, 0);
        tick();
        check("sat_err", bus.inflight_err, 1);
        ready = 1'b0;
        rsp   = 3'b100;
        repeat (8) begin
            tick();
            check("sat_release", bus.channels_credit_release, 3'b100);
        end
        tick();
        check("sat_release_exhausted", bus.channels_credit_release, 3'b000);
        rsp = '0;

        // Reset while an entry is held under backpressure drops it.
        do_reset();
        set_entry(7, 1'b1, 1'b1, 1);
        tick();
        check("midrst_held", bus.isu_valid, 1);
        do_reset();

        // Randomized traffic against the model, with periodic resets.
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 500 == 499) begin
                do_reset();
            end else begin
                ready = ($urandom_range(0, 3) != 0);
                for (int c = 0; c < CHANNEL_NUM; c++) begin
                    rsp[c] = (m_inf[c] > 0 && $urandom_range(0, 2) == 0) ||
                             ($urandom_range(0, 40) == 0);
                end
                repeat (2) begin
                    idx = int'($urandom_range(0, DEPTH - 1));
                    if (!iq_v[idx]) begin
                        set_entry(idx, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                                  int'($urandom_range(0, 2)));
                    end
                end
                idx = int'($urandom_range(0, DEPTH - 1));
                if ($urandom_range(0, 3) == 0) iq_a[idx] = ~iq_a[idx];
                if ($urandom_range(0, 15) == 0) bottom = PTR_WIDTH'($urandom_range(0, DEPTH - 1));
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
